// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the bit-serial arithmetic units.
//   - FSM state encodings (2-bit, legacy-compatible localparam constants)
//   - Legal bounds for the WIDTH parameter and a helper to test them
// No ports (package).
// -----------------------------------------------------------------------------
package arith_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic bit width_is_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Combinational 1-bit full-subtractor cell built from gate primitives.
//   diff  = a ^ b ^ b_in
//   b_out = (~a & b) | (~(a ^ b) & b_in)
// Ports:
//   a     in  minuend bit
//   b     in  subtrahend bit
//   b_in  in  incoming borrow
//   diff  out difference bit
//   b_out out outgoing borrow
// -----------------------------------------------------------------------------
module full_subtractor (
  output logic diff,
  output logic b_out,
  input  logic a,
  input  logic b,
  input  logic b_in
);

  logic w_axb;
  logic w_na;
  logic w_naxb;
  logic w_t1;
  logic w_t2;

  xor g_x1 (w_axb, a, b);
  xor g_x2 (diff, w_axb, b_in);
  not g_n1 (w_na, a);
  and g_a1 (w_t1, w_na, b);
  // Borrow propagates only when the two bits are equal.
  not g_n2 (w_naxb, w_axb);
  and g_a2 (w_t2, w_naxb, b_in);
  or  g_o1 (b_out, w_t1, w_t2);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor: computes a - b one bit per clock,
// LSB first, through a single full_subtractor cell and a registered borrow.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE). An accepted
// start captures a/b and raises busy on the same edge; busy stays high for
// exactly WIDTH cycles, then done pulses for one cycle with diff/borrow_out/
// overflow valid. A start during the done cycle is accepted back-to-back
// (done drops, busy rises). start while busy=1 is ignored. Result outputs
// only change at a completion edge (or reset) and are held otherwise.
//
// Ports:
//   clk         in  rising-edge clock
//   rst_n       in  synchronous active-low reset
//   start       in  operation request
//   a, b        in  minuend / subtrahend (captured on accepted start)
//   busy        out subtraction in progress
//   done        out one-cycle completion pulse
//   diff        out (a - b) mod 2^WIDTH
//   borrow_out  out 1 iff a < b unsigned
//   overflow    out signed overflow of a - b
//   dbg_state   out current FSM state (ST_IDLE/ST_SHIFT/ST_DONE)
// -----------------------------------------------------------------------------
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic             r_bor;
  logic [CW-1:0]    r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_bor_next;
  logic             w_accept;
  logic [WIDTH-1:0] w_r_next;

  full_subtractor u_fs (
    .diff  (w_d),
    .b_out (w_bor_next),
    .a     (r_a_sh[0]),
    .b     (r_b_sh[0]),
    .b_in  (r_bor)
  );

  assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Result bits enter at the MSB so the first (LSB) bit lands in bit 0
  // after WIDTH shifts.
  assign w_r_next = {w_d, r_r_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_r_sh   <= '0;
      r_bor    <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_r_sh  <= '0;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_r_sh <= w_r_next;
          r_bor  <= w_bor_next;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_diff   <= w_r_next;
            r_borrow <= w_bor_next;
            // Signed overflow: operand signs differ and result sign differs
            // from the minuend's sign. w_d here is the result MSB.
            r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Drivers push expected {overflow, borrow, diff} into per-DUT queues; monitors
// pop and compare on every done pulse, and also check result stability while
// busy and the busy run length.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8, bor8, ovf8;
  logic [7:0]  diff8;
  logic [1:0]  st8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy16, done16, bor16, ovf16;
  logic [15:0] diff16;
  logic [1:0]  st16;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  exp8_q[$];
  logic [17:0] exp16_q[$];

  int run8 = 0, run16 = 0;
  int done_cnt8 = 0, done_cnt16 = 0;
  logic [9:0]  last8;
  logic [17:0] last16;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bor8),
    .overflow(ovf8), .dbg_state(st8)
  );

  serial_subtractor #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bor16),
    .overflow(ovf16), .dbg_state(st16)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic logic [33:0] model(input int w, input longint ua, input longint ub);
    longint full = longint'(1) << w;
    longint half = full / 2;
    longint sa   = (ua >= half) ? ua - full : ua;
    longint sb   = (ub >= half) ? ub - full : ub;
    longint sr   = sa - sb;
    longint d    = (ua - ub + full) % full;
    logic   ov   = (sr < -half) || (sr >= half);
    logic   br   = (ua < ub);
    logic [31:0] dv = 32'(d);
    return {ov, br, dv};
  endfunction

  function automatic logic [9:0] exp8(input logic [7:0] av, input logic [7:0] bv);
    logic [33:0] m = model(8, longint'(av), longint'(bv));
    return {m[33:32], m[7:0]};
  endfunction

  function automatic logic [17:0] exp16(input logic [15:0] av, input logic [15:0] bv);
    logic [33:0] m = model(16, longint'(av), longint'(bv));
    return {m[33:32], m[15:0]};
  endfunction

  // ---------------- drivers (start and end on a negedge) ----------------
  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input bit push);
    int guard = 0;
    while (busy8 !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("issue8_timeout", 32'(guard), 32'd0);
    start8 = 1'b1;
    a8 = av;
    b8 = bv;
    if (push) exp8_q.push_back(exp8(av, bv));
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  task automatic issue16(input logic [15:0] av, input logic [15:0] bv);
    int guard = 0;
    while (busy16 !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("issue16_timeout", 32'(guard), 32'd0);
    start16 = 1'b1;
    a16 = av;
    b16 = bv;
    exp16_q.push_back(exp16(av, bv));
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
  endtask

  task automatic wait_not_busy8();
    int guard = 0;
    while (busy8 !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("wait8_timeout", 32'(guard), 32'd0);
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (done8 === 1'b1) begin
      check("busy_len8", 32'(run8), 32'd8);
      check("done_busy_overlap8", 32'(busy8), 32'd0);
      if (exp8_q.size() == 0) begin
        check("unexpected_done8", 32'd1, 32'd0);
      end else begin
        e = exp8_q.pop_front();
        check("diff8", 32'(diff8), 32'(e[7:0]));
        check("borrow8", 32'(bor8), 32'(e[8]));
        check("ovf8", 32'(ovf8), 32'(e[9]));
      end
      done_cnt8++;
      run8 = 0;
    end else if (busy8 === 1'b1) begin
      run8++;
      check("stable8", 32'({ovf8, bor8, diff8}), 32'(last8));
    end else begin
      run8 = 0;
    end
    if (busy8 !== 1'b1) last8 = {ovf8, bor8, diff8};
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (done16 === 1'b1) begin
      check("busy_len16", 32'(run16), 32'd16);
      check("done_busy_overlap16", 32'(busy16), 32'd0);
      if (exp16_q.size() == 0) begin
        check("unexpected_done16", 32'd1, 32'd0);
      end else begin
        e = exp16_q.pop_front();
        check("diff16", 32'(diff16), 32'(e[15:0]));
        check("borrow16", 32'(bor16), 32'(e[16]));
        check("ovf16", 32'(ovf16), 32'(e[17]));
      end
      done_cnt16++;
      run16 = 0;
    end else if (busy16 === 1'b1) begin
      run16++;
      if (32'({ovf16, bor16, diff16}) !== 32'(last16))
        check("stable16", 32'({ovf16, bor16, diff16}), 32'(last16));
    end else begin
      run16 = 0;
    end
    if (busy16 !== 1'b1) last16 = {ovf16, bor16, diff16};
  end

  // ---------------- main sequence ----------------
  logic [7:0] dir_a[5] = '{8'd100, 8'h00, 8'h80, 8'h7F, 8'h55};
  logic [7:0] dir_b[5] = '{8'd37,  8'h01, 8'h01, 8'hFF, 8'h55};

  initial begin
    int base;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_out8", 32'({ovf8, bor8, diff8}), 32'd0);
    check("rst_state8", 32'(st8), 32'd0);
    check("rst_out16", 32'({busy16, done16, ovf16, bor16, diff16}), 32'd0);
    check("rst_state16", 32'(st16), 32'd0);

    // Directed vectors, including the known-answer cases
    for (int i = 0; i < 5; i++) issue8(dir_a[i], dir_b[i], 1'b1);
    wait_not_busy8();
    check("known_100_37", 32'(exp8(8'd100, 8'd37)), 32'h03F);
    check("known_7F_FF", 32'(exp8(8'h7F, 8'hFF)), 32'h380);

    // start held high with operands changing every cycle
    repeat (2) @(negedge clk);
    base = done_cnt8;
    for (int k = 0; k < 27; k++) begin
      start8 = 1'b1;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (k % 9 == 0) exp8_q.push_back(exp8(a8, b8));
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("held_start_done_count", 32'(done_cnt8 - base), 32'd3);

    // Reset in the 4th SHIFT cycle discards the operation
    wait_not_busy8();
    repeat (2) @(negedge clk);
    start8 = 1'b1;
    a8 = 8'd200;
    b8 = 8'd13;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_out", 32'({ovf8, bor8, diff8}), 32'd0);
    check("midrst_state", 32'(st8), 32'd0);
    base = done_cnt8;
    repeat (12) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt8 - base), 32'd0);
    issue8(8'd20, 8'd30, 1'b1);
    wait_not_busy8();
    @(negedge clk);
    check("after_rst_diff", 32'(diff8), 32'hF6);
    check("after_rst_borrow", 32'(bor8), 32'd1);

    // Random runs on both widths in parallel
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          issue8(8'($urandom), 8'($urandom), 1'b1);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          issue16(16'($urandom), 16'($urandom));
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join

    repeat (40) @(negedge clk);
    check("drain8", 32'(exp8_q.size()), 32'd0);
    check("drain16", 32'(exp16_q.size()), 32'd0);
    check("done_total8", 32'(done_cnt8), 32'd1009);
    check("done_total16", 32'(done_cnt16), 32'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
